adi_dma_comb_ctrl: RTL

Packet-count sequencer for the DMA combiner AXIS path. It gates the slave-to-master stream so that exactly num_pkts TLAST-terminated packets pass after a start command, then closes. It supports abort-at-packet-boundary, a continuous mode and sticky status flags. Placement: between the AXI-Lite register interface (cmd/num_pkts/status) and the combiner datapath. All control inputs are already synchronous to AXIS_ACLK.

---
 rtl/adi_dma_comb_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/adi_dma_comb_ctrl.sv
// adi_dma_comb_ctrl: gates an AXIS stream to num_pkts packets per start.
// Optional stall timeout: define ADI_DMA_COMB_CTRL_TIMEOUT_EN.
module adi_dma_comb_ctrl #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESET,
  input  logic [31:0]          cmd,
  input  logic [CNT_WIDTH-1:0] num_pkts,
  output logic [31:0]          status,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  input  logic                 S_AXIS_TVALID,
  input  logic [63:0]          S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST,
  output logic                 S_AXIS_TREADY,
  output logic                 M_AXIS_TVALID,
  output logic [63:0]          M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY
);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DONE, ERROR
  } state_t;

  state_t               state;
  logic                 gate;
  logic                 start_q;
  logic                 in_packet;
  logic                 done_f;
  logic                 abort_f;
  logic                 tout_f;
  logic                 reached;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] cnt;

  logic start, abort, cont, clr, start_edge;
  logic busy, beat, eop, fin, stall_hit, unused;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign start      = cmd[0];
  assign abort      = cmd[1];
  assign cont       = cmd[2];
  assign clr        = cmd[3];
  assign start_edge = start & ~start_q;

  assign busy    = (state == RUN) || (state == DRAIN);
  assign beat    = S_AXIS_TVALID & S_AXIS_TREADY;
  assign eop     = beat & S_AXIS_TLAST;
  assign cnt_inc = cnt + 1'b1;
  assign fin     = eop & ~cont & ~reached & (cnt_inc == target);

  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign M_AXIS_TVALID = S_AXIS_TVALID & gate;
  assign S_AXIS_TREADY = M_AXIS_TREADY & gate;

  assign pkt_cnt = cnt;
  assign status  = {cnt[15:0], 11'd0, in_packet,
                    tout_f, abort_f, done_f, busy};

`ifdef ADI_DMA_COMB_CTRL_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall;

  assign stall_hit = busy & in_packet & ~beat &
                     (stall + 1'b1 == SW'(TIMEOUT_CYCLES));
  assign unused    = ^cmd[31:4];

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      stall  <= '0;
      tout_f <= 1'b0;
    end else begin
      if (busy & in_packet & ~beat) stall <= stall + 1'b1;
      else                          stall <= '0;
      if (stall_hit)
        tout_f <= 1'b1;
      else if (!busy & (start_edge | clr))
        tout_f <= 1'b0;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign tout_f    = 1'b0;
  assign unused    = ^{cmd[31:4], (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state     <= IDLE;
      gate      <= 1'b0;
      start_q   <= 1'b0;
      in_packet <= 1'b0;
      done_f    <= 1'b0;
      abort_f   <= 1'b0;
      reached   <= 1'b0;
      target    <= '0;
      cnt       <= '0;
    end else begin
      start_q <= start;
      if (beat & ~S_AXIS_TLAST) in_packet <= 1'b1;
      else if (eop)             in_packet <= 1'b0;

      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start_edge) begin
            target    <= num_pkts;
            cnt       <= '0;
            done_f    <= 1'b0;
            abort_f   <= 1'b0;
            reached   <= 1'b0;
            in_packet <= 1'b0;
            if (num_pkts == '0 && !cont) begin
              state  <= DONE;
              done_f <= 1'b1;
              gate   <= 1'b0;
            end else begin
              state <= RUN;
              gate  <= 1'b1;
            end
          end else if (clr) begin
            state   <= IDLE;
            done_f  <= 1'b0;
            abort_f <= 1'b0;
          end
        end
        RUN: begin
          if (eop) cnt <= cnt_inc;
          if (stall_hit) begin
            state     <= ERROR;
            gate      <= 1'b0;
            in_packet <= 1'b0;
          end else if (fin) begin
            state   <= DONE;
            done_f  <= 1'b1;
            reached <= 1'b1;
            gate    <= 1'b0;
          end else if (abort) begin
            // An eop this cycle already sits on a packet boundary.
            if (eop || (!in_packet && !beat)) begin
              state   <= DONE;
              abort_f <= 1'b1;
              gate    <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (stall_hit) begin
            state     <= ERROR;
            gate      <= 1'b0;
            in_packet <= 1'b0;
          end else if (eop) begin
            cnt     <= cnt_inc;
            state   <= DONE;
            abort_f <= 1'b1;
            gate    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gate  <= 1'b0;
        end
      endcase
    end
  end

endmodule
